// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width helper for the sequential multiplier
//
// Purpose : constants and helper functions shared by the multiplier files.
// Contents: FSM state encodings (IDLE/RUN/FINISH), state_t, clog2().
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// rtl/Full_Adder.sv - one-bit full adder cell
//
// Purpose : single-bit full adder, the building block of the ripple adder.
// Ports   : A, B, cin  - addend bits and carry in
//           sum, cout  - sum bit and carry out
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = A ^ B ^ cin;
  assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/nbit_ripple_adder.sv
// rtl/nbit_ripple_adder.sv - N-bit ripple-carry adder built from Full_Adder cells
//
// Purpose : sum = A + B + cin over N bits, carry out on cout.
// Ports   : A, B [N-1:0] - addends
//           cin          - carry in
//           sum  [N-1:0] - result
//           cout         - carry out of the top bit
module nbit_ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    Full_Adder u_fa (
      .A    (A[i]),
      .B    (B[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/nbit_seq_multiplier.sv
// rtl/nbit_seq_multiplier.sv - N-bit shift-and-add sequential multiplier, signed/unsigned
//
// Purpose : computes a 2N-bit product of two N-bit operands in N+1 cycles
//           using one shared ripple adder; signed mode works on magnitudes
//           and negates the result at the end.
// Ports   : clk                 - rising-edge clock
//           resetN              - asynchronous active-low reset
//           start               - request, accepted in IDLE or FINISH
//           signedMode          - 1 = two's complement, sampled with start
//           inputM, inputQ[N-1:0] - multiplicand / multiplier, sampled with start
//           busy                - high in RUN and FINISH
//           done                - one-cycle pulse when product is written
//           product[2N-1:0]     - result, held until the next FINISH
module nbit_seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           start,
  input  logic           signedMode,
  input  logic [N-1:0]   inputM,
  input  logic [N-1:0]   inputQ,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = clog2(N);

  state_t         state;
  logic [N-1:0]   m_reg;
  logic [N-1:0]   q_reg;
  logic [2*N:0]   acc;
  logic [CW-1:0]  cnt;
  logic           neg_flag;

  logic           load;
  logic           last_iter;
  logic [N-1:0]   mag_m;
  logic [N-1:0]   mag_q;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic [N:0]     acc_hi_next;
  logic [2*N:0]   acc_next;
  logic [2*N-1:0] neg_sum;
  logic           unused_neg_cout;

  assign load      = start & ((state == IDLE) | (state == FINISH));
  assign last_iter = (cnt == CW'(N - 1));

  // Magnitudes; -2^(N-1) negates to itself, which read unsigned is 2^(N-1).
  assign mag_m = (signedMode & inputM[N-1]) ? (~inputM + N'(1)) : inputM;
  assign mag_q = (signedMode & inputQ[N-1]) ? (~inputQ + N'(1)) : inputQ;

  // The top bit of acc_hi is always 0 when an add happens (it was just
  // shifted in as 0), so an N-bit add plus carry-out covers acc_hi + M.
  nbit_ripple_adder #(.N(N)) u_acc_adder (
    .A    (acc[2*N-1:N]),
    .B    (m_reg),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_hi_next = q_reg[0] ? {add_cout, add_sum} : acc[2*N:N];
  assign acc_next    = {1'b0, acc_hi_next, acc[N-1:1]};

  // Two's-complement negation of the finished product: ~acc + 1.
  nbit_ripple_adder #(.N(2*N)) u_neg_adder (
    .A    (~acc[2*N-1:0]),
    .B    ('0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (unused_neg_cout)
  );

  assign busy = (state == RUN) | (state == FINISH);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      m_reg    <= '0;
      q_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;

      // The FINISH edge publishes the result even when a new start is
      // captured on the same edge; acc is not touched until RUN begins.
      if (state == FINISH) begin
        product <= neg_flag ? neg_sum : acc[2*N-1:0];
        done    <= 1'b1;
      end

      if (load) begin
        m_reg    <= mag_m;
        q_reg    <= mag_q;
        neg_flag <= signedMode & (inputM[N-1] ^ inputQ[N-1]);
        acc      <= '0;
        cnt      <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        q_reg <= q_reg >> 1;
        cnt   <= cnt + CW'(1);
      end

      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_iter) state <= FINISH;
        FINISH:  state <= start ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_seq_multiplier.sv
// tb/tb_nbit_seq_multiplier.sv - self-checking bench for nbit_seq_multiplier (N=8 and N=4)
module tb_nbit_seq_multiplier;

  logic        clk = 1'b0;
  logic        resetN;

  logic        start8, s8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;

  logic        start4, s4, busy4, done4;
  logic [3:0]  m4, q4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nbit_seq_multiplier #(.N(8)) dut8 (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start8),
    .signedMode (s8),
    .inputM     (m8),
    .inputQ     (q8),
    .busy       (busy8),
    .done       (done8),
    .product    (p8)
  );

  nbit_seq_multiplier #(.N(4)) dut4 (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start4),
    .signedMode (s4),
    .inputM     (m4),
    .inputQ     (q4),
    .busy       (busy4),
    .done       (done4),
    .product    (p4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted by mode.
  function automatic logic [15:0] model(input int n, input logic [7:0] m,
                                        input logic [7:0] q, input bit s);
    longint a, b, p, mask;
    mask = (longint'(1) << n) - 1;
    a = longint'(m) & mask;
    b = longint'(q) & mask;
    if (s && a >= (longint'(1) << (n - 1))) a = a - (longint'(1) << n);
    if (s && b >= (longint'(1) << (n - 1))) b = b - (longint'(1) << n);
    p = (a * b) & ((longint'(1) << (2 * n)) - 1);
    return 16'(p);
  endfunction

  function automatic bit dn(input bit w4);
    return w4 ? done4 : done8;
  endfunction

  function automatic bit bs(input bit w4);
    return w4 ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] pr(input bit w4);
    return w4 ? {8'h00, p4} : p8;
  endfunction

  task automatic drive(input bit w4, input bit st, input logic [7:0] m,
                       input logic [7:0] q, input bit s);
    if (w4) begin
      start4 = st; m4 = m[3:0]; q4 = q[3:0]; s4 = s;
    end else begin
      start8 = st; m8 = m; q8 = q; s8 = s;
    end
  endtask

  // Waits (bounded) for done, counting edges since the current sample point.
  task automatic wait_done(input bit w4, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dn(w4)) break;
    end
  endtask

  task automatic run_op(input bit w4, input logic [7:0] m, input logic [7:0] q,
                        input bit s, input logic [15:0] exp, input string tag);
    int  n, lat, bcnt;
    bit  seen;
    n = w4 ? 4 : 8;
    @(negedge clk);
    drive(w4, 1'b1, m, q, s);
    @(posedge clk); #1;
    drive(w4, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    lat  = 0;
    bcnt = bs(w4) ? 1 : 0;
    seen = 0;
    while (!seen && lat < 3 * n) begin
      @(posedge clk); #1;
      lat++;
      if (dn(w4)) seen = 1;
      else if (bs(w4)) bcnt++;
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, lat, n + 1);
    check({tag, "_busy_cycles"}, bcnt, n + 1);
    check({tag, "_busy_after"}, bs(w4), 0);
    check({tag, "_product"}, pr(w4), exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, dn(w4), 0);
    check({tag, "_held"}, pr(w4), exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, dcount, first;
    logic [7:0] m, q;
    bit s, w4;

    resetN = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_prod8", p8, 0);
    check("rst_busy4", busy4, 0);
    check("rst_prod4", p4, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy8", busy8, 0);
    check("post_rst_done8", done8, 0);

    // Directed cases
    run_op(1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    run_op(1'b0, 8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_m128");
    run_op(1'b0, 8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3_5");
    run_op(1'b0, 8'h7F, 8'hFF, 1'b1, 16'hFF81, "s_127_m1");
    run_op(1'b0, 8'h00, 8'hA5, 1'b1, 16'h0000, "s_zero");
    run_op(1'b0, 8'h01, 8'hA5, 1'b0, 16'h00A5, "u_ident");
    run_op(1'b1, 8'h0F, 8'h0F, 1'b0, 16'h00E1, "n4_u_f_f");
    run_op(1'b1, 8'h08, 8'h07, 1'b1, 16'h00C8, "n4_s_m8_7");

    // Back-to-back: start held high through RUN into FINISH
    run_op(1'b0, 8'h03, 8'h03, 1'b0, 16'h0009, "pre_b2b");
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00, 8'hA5, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'h01, 8'hA5, 1'b0);
    wait_done(1'b0, lat);
    check("b2b_first_latency", lat, 9);
    check("b2b_first_product", p8, 16'h0000);
    check("b2b_busy_stays", busy8, 1);
    drive(1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1);
    wait_done(1'b0, lat);
    check("b2b_second_spacing", lat, 9);
    check("b2b_second_product", p8, 16'h00A5);
    @(posedge clk); #1;
    check("b2b_idle_after", busy8, 0);

    // Start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd200, 8'd3, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd200, 8'd3, 1'b0);
    dcount = 0;
    first  = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        dcount++;
        if (first == 0) begin
          first = c;
          check("midrun_product", p8, 16'h0258);
        end
      end
      if (c == 3) drive(1'b0, 1'b1, 8'd17, 8'd19, 1'b1);
      if (c == 4) drive(1'b0, 1'b0, 8'd17, 8'd19, 1'b1);
    end
    check("midrun_done_count", dcount, 1);
    check("midrun_latency", first, 9);

    // Reset at iteration 4 discards the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h7B, 8'h3C, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("midreset_busy_before", busy8, 1);
    resetN = 1'b0;
    #1;
    check("midreset_busy", busy8, 0);
    check("midreset_done", done8, 0);
    check("midreset_product", p8, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done8) dcount++;
    end
    check("midreset_no_done", dcount, 0);
    run_op(1'b0, 8'h7B, 8'h3C, 1'b0, 16'h1CD4, "after_reset");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      m  = 8'($urandom);
      q  = 8'($urandom);
      s  = 1'($urandom);
      w4 = (i % 3) == 2;
      if (i == 0) begin m = 8'h80; q = 8'h7F; s = 1'b1; end
      run_op(w4, m, q, s, model(w4 ? 4 : 8, m, q, s), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
